// File: rtl/byte_bus_pkg.sv
// byte_bus_pkg
//   Shared definitions for the 4-requester byte bus arbiter: requester count,
//   byte width, FSM state encoding and the round-robin search helper.
package byte_bus_pkg;

  localparam int N_REQ  = 4;
  localparam int BYTE_W = 8;
  localparam int IDX_W  = 2;
  localparam int HOLD_W = 4;

  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of vec at or after start, wrapping 3->0. The loop walks
  // from the farthest position to the nearest so the nearest one wins.
  function automatic rr_pick_t rr_pick(input logic [N_REQ-1:0] vec,
                                       input logic [IDX_W-1:0] start);
    rr_pick_t         res;
    logic [IDX_W-1:0] idx;
    res.found = 1'b0;
    res.idx   = start;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = start + k[IDX_W-1:0];
      if (vec[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/byte_bus_mux.sv
// byte_bus_mux
//   4:1 byte select driven by the arbiter's owner index, forced to zero when
//   no grant is active so an idle bus always reads 8'h00.
// Ports:
//   i_valid      : bus has an active grant
//   i_sel        : owner index selecting one of the four bytes
//   i_d0..i_d3   : requester data bytes
//   o_data       : selected byte, or 8'h00 when i_valid is low
module byte_bus_mux
  import byte_bus_pkg::*;
(
  input  logic              i_valid,
  input  logic [IDX_W-1:0]  i_sel,
  input  logic [BYTE_W-1:0] i_d0,
  input  logic [BYTE_W-1:0] i_d1,
  input  logic [BYTE_W-1:0] i_d2,
  input  logic [BYTE_W-1:0] i_d3,
  output logic [BYTE_W-1:0] o_data
);

  always_comb begin
    o_data = '0;
    if (i_valid) begin
      case (i_sel)
        2'd0:    o_data = i_d0;
        2'd1:    o_data = i_d1;
        2'd2:    o_data = i_d2;
        default: o_data = i_d3;
      endcase
    end
  end

endmodule

// File: rtl/byte_bus_arbiter.sv
// byte_bus_arbiter
//   Round-robin arbiter for four requesters sharing one byte bus. A holder
//   keeps the bus while it requests, but is forced to rotate after MAX_HOLD
//   consecutive cycles if anyone else is waiting.
//
//   Handshake: req[i] is a level request sampled only at the rising edge of
//   clk; the registered grant appears one cycle later. A requester owns the
//   bus for every cycle grant[i] is high, and releases it by dropping req[i]
//   (the next owner is granted on that same edge, with no idle bubble).
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   req[3:0]        : per-requester bus request
//   in0..in3        : requester data bytes
//   grant[3:0]      : registered one-hot (or zero) grant
//   owner[1:0]      : index of current or last grantee
//   bus_valid       : grant is nonzero
//   out[7:0]        : shared bus byte, in[owner] or 8'h00 when idle
//   dbg_state       : FSM state (IDLE/BUSY)
//   dbg_hold_cnt    : consecutive-grant counter of the current owner
module byte_bus_arbiter
  import byte_bus_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req,
  input  logic [BYTE_W-1:0] in0,
  input  logic [BYTE_W-1:0] in1,
  input  logic [BYTE_W-1:0] in2,
  input  logic [BYTE_W-1:0] in3,
  output logic [N_REQ-1:0]  grant,
  output logic [IDX_W-1:0]  owner,
  output logic              bus_valid,
  output logic [BYTE_W-1:0] out,
  output state_e            dbg_state,
  output logic [HOLD_W-1:0] dbg_hold_cnt
);

  localparam logic [HOLD_W-1:0] C_MAX_HOLD = MAX_HOLD[HOLD_W-1:0];

  state_e            r_state;
  logic [N_REQ-1:0]  r_grant;
  logic [IDX_W-1:0]  r_owner;
  logic [IDX_W-1:0]  r_ptr;
  logic [HOLD_W-1:0] r_hold_cnt;

  state_e            w_state_nx;
  logic [N_REQ-1:0]  w_grant_nx;
  logic [IDX_W-1:0]  w_owner_nx;
  logic [IDX_W-1:0]  w_ptr_nx;
  logic [HOLD_W-1:0] w_hold_nx;

  rr_pick_t          w_pick_any;
  rr_pick_t          w_pick_other;
  logic              w_owner_req;

  assign w_pick_any   = rr_pick(req, r_ptr);
  // While busy r_grant is the owner's one-hot bit, so masking with it leaves
  // only the competing requesters for a forced rotation.
  assign w_pick_other = rr_pick(req & ~r_grant, r_ptr);
  assign w_owner_req  = req[r_owner];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_grant    <= w_grant_nx;
      r_owner    <= w_owner_nx;
      r_ptr      <= w_ptr_nx;
      r_hold_cnt <= w_hold_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_owner_nx = r_owner;
    w_ptr_nx   = r_ptr;
    w_hold_nx  = r_hold_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any.found) begin
          w_state_nx = ST_BUSY;
          w_grant_nx = idx_to_onehot(w_pick_any.idx);
          w_owner_nx = w_pick_any.idx;
          w_ptr_nx   = w_pick_any.idx + 2'd1;
          w_hold_nx  = HOLD_ONE;
        end
      end
      ST_BUSY: begin
        if (!w_owner_req) begin
          // Owner released: hand over on this edge, or fall idle. owner keeps
          // the last grantee so it still names who held the bus.
          if (w_pick_any.found) begin
            w_grant_nx = idx_to_onehot(w_pick_any.idx);
            w_owner_nx = w_pick_any.idx;
            w_ptr_nx   = w_pick_any.idx + 2'd1;
            w_hold_nx  = HOLD_ONE;
          end else begin
            w_state_nx = ST_IDLE;
            w_grant_nx = '0;
            w_hold_nx  = '0;
          end
        end else if (r_hold_cnt < C_MAX_HOLD) begin
          w_hold_nx = r_hold_cnt + HOLD_ONE;
        end else if (w_pick_other.found) begin
          w_grant_nx = idx_to_onehot(w_pick_other.idx);
          w_owner_nx = w_pick_other.idx;
          w_ptr_nx   = w_pick_other.idx + 2'd1;
          w_hold_nx  = HOLD_ONE;
        end else begin
          // Sole requester past its budget: keep the bus, counter saturates.
          w_hold_nx = C_MAX_HOLD;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_grant_nx = '0;
        w_hold_nx  = '0;
      end
    endcase
  end

  assign grant        = r_grant;
  assign owner        = r_owner;
  assign bus_valid    = |r_grant;
  assign dbg_state    = r_state;
  assign dbg_hold_cnt = r_hold_cnt;

  byte_bus_mux u_mux (
    .i_valid (bus_valid),
    .i_sel   (r_owner),
    .i_d0    (in0),
    .i_d1    (in1),
    .i_d2    (in2),
    .i_d3    (in3),
    .o_data  (out)
  );

endmodule

// File: tb/tb_byte_bus_arbiter.sv
// tb_byte_bus_arbiter
//   Directed bench for byte_bus_arbiter with a rule-level reference model
//   compared every cycle, plus literal expectations for the key scenarios.
module tb_byte_bus_arbiter;
  import byte_bus_pkg::*;

  localparam int MAX = 4;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [7:0] in0, in1, in2, in3;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       bus_valid;
  logic [7:0] out;
  state_e     dbg_state;
  logic [3:0] dbg_hold_cnt;

  int total = 0;
  int bad   = 0;

  byte_bus_arbiter #(.MAX_HOLD(MAX)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .in0          (in0),
    .in1          (in1),
    .in2          (in2),
    .in3          (in3),
    .grant        (grant),
    .owner        (owner),
    .bus_valid    (bus_valid),
    .out          (out),
    .dbg_state    (dbg_state),
    .dbg_hold_cnt (dbg_hold_cnt)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_live = 0;
  bit m_busy = 0;
  int m_owner = 0;
  int m_ptr = 0;
  int m_hold = 0;

  function automatic int first_from(input logic [3:0] v, input int start);
    for (int k = 0; k < 4; k++)
      if (v[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  function automatic logic [7:0] in_of(input int i);
    case (i)
      0: return in0;
      1: return in1;
      2: return in2;
      default: return in3;
    endcase
  endfunction

  task automatic m_take(input int p);
    m_busy  = 1;
    m_owner = p;
    m_ptr   = (p + 1) % 4;
    m_hold  = 1;
  endtask

  always @(posedge clk) begin
    int p;
    if (reset) begin
      m_live = 1; m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0;
    end else if (m_live) begin
      if (!m_busy) begin
        p = first_from(req, m_ptr);
        if (p >= 0) m_take(p);
      end else if (!req[m_owner]) begin
        p = first_from(req, m_ptr);
        if (p >= 0) m_take(p);
        else begin m_busy = 0; m_hold = 0; end
      end else if (m_hold < MAX) begin
        m_hold++;
      end else begin
        p = first_from(req & ~(4'b0001 << m_owner), m_ptr);
        if (p >= 0) m_take(p);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_live) begin
      chk("mdl_grant", grant, m_busy ? (32'd1 << m_owner) : 32'd0);
      chk("mdl_owner", owner, m_owner);
      chk("mdl_valid", bus_valid, m_busy);
      chk("mdl_out", out, m_busy ? in_of(m_owner) : 8'h00);
      chk("mdl_state", dbg_state, m_busy ? ST_BUSY : ST_IDLE);
      if (m_busy) chk("mdl_hold", dbg_hold_cnt, m_hold);
    end
  end

  // ---------------- directed stimulus ----------------
  // Inputs change 1 time unit after a falling edge; outputs are read on
  // falling edges, so each @(negedge) below spans exactly one rising edge.
  logic [3:0] tbl [16] = '{4'b1001, 4'b1001, 4'b0110, 4'b0000, 4'b1000, 4'b1111,
                           4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0011, 4'b0001,
                           4'b0000, 4'b0100, 4'b1110, 4'b0000};
  int exp_own [12] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3};

  initial begin
    reset = 1'b1; req = 4'b0000;
    in0 = 8'hA5; in1 = 8'h11; in2 = 8'h22; in3 = 8'h33;
    @(negedge clk); @(negedge clk);
    chk("rst_grant", grant, 4'b0000);
    chk("rst_owner", owner, 2'd0);
    chk("rst_valid", bus_valid, 1'b0);
    chk("rst_out", out, 8'h00);

    // single requester 0
    #1 reset = 1'b0; req = 4'b0001;
    @(negedge clk);
    chk("r026_grant", grant, 4'b0001);
    chk("r026_owner", owner, 2'd0);
    chk("r026_valid", bus_valid, 1'b1);
    chk("r026_out", out, 8'hA5);

    // everyone requesting: four cycles each, no gaps
    #1 req = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("r027_owner", owner, exp_own[i]);
      chk("r027_valid", bus_valid, 1'b1);
    end

    // owner 3 releases -> 1; then 1 releases while 3 waits -> 3
    #1 req = 4'b0010;
    @(negedge clk);
    chk("r028_pre_grant", grant, 4'b0010);
    #1 req = 4'b1010;
    @(negedge clk);
    chk("r028_pre_hold", dbg_hold_cnt, 4'd2);
    #1 req = 4'b1000;
    @(negedge clk);
    chk("r028_grant", grant, 4'b1000);
    chk("r028_out", out, 8'h33);
    chk("r028_hold", dbg_hold_cnt, 4'd1);

    // lone requester 2 held ten cycles
    #1 req = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("r029_grant", grant, 4'b0100);
    end
    chk("r029_hold_sat", dbg_hold_cnt, 4'd4);

    // release all, then 0101 from ptr=3 picks 0
    #1 req = 4'b0000;
    @(negedge clk);
    chk("r030_grant0", grant, 4'b0000);
    chk("r030_valid0", bus_valid, 1'b0);
    chk("r030_out0", out, 8'h00);
    #1 req = 4'b0101;
    @(negedge clk);
    chk("r030_grant", grant, 4'b0001);

    // reset in the middle of a busy period
    #1 req = 4'b1111;
    @(negedge clk); @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("r031_grant_rst", grant, 4'b0000);
    chk("r031_out_rst", out, 8'h00);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("r031_grant", grant, 4'b0001);
    chk("r031_owner", owner, 2'd0);

    // a request pulse between edges is never seen
    #1 req = 4'b0000;
    @(negedge clk);
    #1 req = 4'b0010;
    #2 req = 4'b0000;
    @(negedge clk);
    chk("r021_glitch", grant, 4'b0000);

    // mixed table, checked by the model only
    for (int i = 0; i < 16; i++) begin
      #1 req = tbl[i];
      in0 = 8'h40 + 8'(i); in2 = 8'hC0 - 8'(i);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
